// File: rtl/audio_pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// audio_pll_sup_pkg
// Shared types and default timing constants for the audio PLL supervisor.
// The defaults assume a 74.25 MHz reference clock:
//   RST_HOLD_CYCLES  256     refclk cycles the PLL reset is held per attempt
//   LOCK_TIMEOUT     742500  10 ms window for the PLL to report lock
//   SETTLE_CYCLES    7425    100 us of continuous lock before declaring ready
//   LOSS_FILT        16      consecutive unlocked cycles treated as real loss
//   MAX_RETRIES      3       lock timeouts tolerated before a sticky fault
//   TIMER_W          20      shared timer width, wide enough for LOCK_TIMEOUT-1
// ---------------------------------------------------------------------------
package audio_pll_sup_pkg;

  // The numeric values are visible on the state output, so they are pinned.
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pllState_e;

  localparam int DEF_RST_HOLD_CYCLES = 256;
  localparam int DEF_LOCK_TIMEOUT    = 742500;
  localparam int DEF_SETTLE_CYCLES   = 7425;
  localparam int DEF_LOSS_FILT       = 16;
  localparam int DEF_MAX_RETRIES     = 3;
  localparam int DEF_TIMER_W         = 20;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single asynchronous bit. Both flops
// reset to 0, so a synchronised "active" indication is never reported
// straight out of reset. Latency is two clk_i cycles.
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high reset
//   d_i    asynchronous input bit
//   q_o    synchronised output bit
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; the second gives it a full cycle to
  // resolve before anything downstream looks at the value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_pll_supervisor.sv
// ---------------------------------------------------------------------------
// audio_pll_supervisor
// Sequences the audio PLL (MCLK 12.288 MHz / SCLK 3.072 MHz from 74.25 MHz):
// holds the PLL in reset, waits for a qualified lock, lets it settle, then
// raises audio_ready. Lock loss while running restarts the PLL and is counted;
// repeated lock timeouts latch a sticky fault. Everything runs on the
// free-running reference clock so the supervisor never depends on the PLL.
// Ports:
//   refclk_i            reference clock, the only clock
//   rst_i               synchronous active-high reset
//   pll_locked_async_i  PLL lock indication, asynchronous to refclk_i
//   restart_req_i       single-cycle request to restart the PLL
//   pll_rst_o           registered PLL reset
//   audio_ready_o       PLL outputs valid; gates downstream audio logic
//   fault_o             sticky: lock never achieved within the retry budget
//   relock_count_o      lock-loss events seen while running, saturating
//   state_o             current state encoding for status/debug
// ---------------------------------------------------------------------------
module audio_pll_supervisor
  import audio_pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int LOSS_FILT       = DEF_LOSS_FILT,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int TIMER_W         = DEF_TIMER_W
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_async_i,
  input  logic       restart_req_i,
  output logic       pll_rst_o,
  output logic       audio_ready_o,
  output logic       fault_o,
  output logic [7:0] relock_count_o,
  output logic [2:0] state_o
);

  localparam int LOSS_W = $clog2(LOSS_FILT + 1);
  localparam int ATT_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_ONE    = LOSS_W'(1);
  localparam logic [ATT_W-1:0]   ATT_MAX     = ATT_W'(MAX_RETRIES);
  localparam logic [ATT_W-1:0]   ATT_ONE     = ATT_W'(1);

  // Parameter sanity: every window must be countable by the shared timer.
  if (longint'(LOCK_TIMEOUT) > (longint'(1) << TIMER_W)) begin : gen_chk_lock
    $error("LOCK_TIMEOUT does not fit in TIMER_W bits");
  end
  if (longint'(SETTLE_CYCLES) > (longint'(1) << TIMER_W)) begin : gen_chk_settle
    $error("SETTLE_CYCLES does not fit in TIMER_W bits");
  end
  if (longint'(RST_HOLD_CYCLES) > (longint'(1) << TIMER_W)) begin : gen_chk_hold
    $error("RST_HOLD_CYCLES does not fit in TIMER_W bits");
  end
  if (LOSS_FILT < 1) begin : gen_chk_loss
    $error("LOSS_FILT must be at least 1");
  end
  if (MAX_RETRIES < 1) begin : gen_chk_retries
    $error("MAX_RETRIES must be at least 1");
  end

  logic lockS;

  pllState_e          state_q,      state_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
  logic [ATT_W-1:0]   attempts_q,   attempts_d;
  logic [LOSS_W-1:0]  lossCnt_q,    lossCnt_d;
  logic [7:0]         relockCnt_q,  relockCnt_d;
  logic               pllRst_q,     pllRst_d;
  logic               audioReady_q, audioReady_d;
  logic               fault_q,      fault_d;

  sync_2ff u_lock_sync (
    .clk_i (refclk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_async_i),
    .q_o   (lockS)
  );

  // Next-state logic. A restart request overrides whatever the FSM would do.
  // The loss counter defaults to zero so it only accumulates while in RUN
  // with lock missing; any locked cycle or any other state clears it.
  // The registered outputs are derived from the next state, which keeps
  // audio_ready and pll_rst glitch-free and aligned with the state register.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    attempts_d  = attempts_q;
    lossCnt_d   = '0;
    relockCnt_d = relockCnt_q;

    if (restart_req_i) begin
      state_d    = HOLD;
      timer_d    = '0;
      attempts_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lockS) begin
            state_d = SETTLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            timer_d    = '0;
            attempts_d = attempts_q + ATT_ONE;
            state_d    = (attempts_d == ATT_MAX) ? FAULT : HOLD;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        SETTLE: begin
          if (!lockS) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == SETTLE_LAST) begin
            state_d    = RUN;
            timer_d    = '0;
            attempts_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        RUN: begin
          if (!lockS) begin
            if (lossCnt_q == LOSS_LAST) begin
              state_d = HOLD;
              timer_d = '0;
              if (relockCnt_q != 8'hFF) begin
                relockCnt_d = relockCnt_q + 8'd1;
              end
            end else begin
              lossCnt_d = lossCnt_q + LOSS_ONE;
            end
          end
        end
        FAULT: begin
          timer_d = '0;
        end
        default: begin
          state_d    = HOLD;
          timer_d    = '0;
          attempts_d = '0;
        end
      endcase
    end

    pllRst_d     = (state_d == HOLD) || (state_d == FAULT);
    audioReady_d = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  // State and output registers. Reset puts the PLL straight into reset so it
  // is never left free-running with unknown configuration.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q      <= HOLD;
      timer_q      <= '0;
      attempts_q   <= '0;
      lossCnt_q    <= '0;
      relockCnt_q  <= '0;
      pllRst_q     <= 1'b1;
      audioReady_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      attempts_q   <= attempts_d;
      lossCnt_q    <= lossCnt_d;
      relockCnt_q  <= relockCnt_d;
      pllRst_q     <= pllRst_d;
      audioReady_q <= audioReady_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_rst_o      = pllRst_q;
  assign audio_ready_o  = audioReady_q;
  assign fault_o        = fault_q;
  assign relock_count_o = relockCnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// ---------------------------------------------------------------------------
// tb_audio_pll_supervisor
// Directed bench for the audio PLL supervisor with shortened timing
// (hold 4, timeout 20, settle 8, loss filter 3, 2 retries). Each step pushes
// the expected status snapshot into a scoreboard queue, advances the clock,
// then pops and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_audio_pll_supervisor;
  import audio_pll_sup_pkg::*;

  localparam int RST_HOLD = 4;
  localparam int LOCK_TO  = 20;
  localparam int SETTLE_N = 8;
  localparam int LOSS_N   = 3;
  localparam int RETRIES  = 2;

  logic       refclk     = 1'b0;
  logic       rst        = 1'b1;
  logic       lockAsync  = 1'b0;
  logic       restartReq = 1'b0;
  logic       pllRst;
  logic       audioReady;
  logic       fault;
  logic [7:0] relockCount;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       prst;
    logic       rdy;
    logic       flt;
    logic [7:0] rc;
  } expect_t;

  expect_t expQ[$];

  audio_pll_supervisor #(
    .RST_HOLD_CYCLES (RST_HOLD),
    .LOCK_TIMEOUT    (LOCK_TO),
    .SETTLE_CYCLES   (SETTLE_N),
    .LOSS_FILT       (LOSS_N),
    .MAX_RETRIES     (RETRIES),
    .TIMER_W         (20)
  ) dut (
    .refclk_i           (refclk),
    .rst_i              (rst),
    .pll_locked_async_i (lockAsync),
    .restart_req_i      (restartReq),
    .pll_rst_o          (pllRst),
    .audio_ready_o      (audioReady),
    .fault_o            (fault),
    .relock_count_o     (relockCount),
    .state_o            (state)
  );

  // Free-running reference clock.
  always #5 refclk = ~refclk;

  // Advance a number of clock cycles; inputs change and outputs are sampled
  // 2 time units after each rising edge, well clear of the edge itself.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge refclk);
      #2;
    end
  endtask

  task automatic pushExp(input string tag, input logic [2:0] st, input logic prst,
                         input logic rdy, input logic flt, input logic [7:0] rc);
    expect_t e;
    e.tag  = tag;
    e.st   = st;
    e.prst = prst;
    e.rdy  = rdy;
    e.flt  = flt;
    e.rc   = rc;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare the whole status snapshot.
  task automatic checkOutput();
    expect_t e;
    e = expQ.pop_front();
    checks++;
    assert ({state, pllRst, audioReady, fault, relockCount} ===
            {e.st, e.prst, e.rdy, e.flt, e.rc})
    else begin
      errors++;
      $display("[TB] FAIL %s: observed state=%0d pll_rst=%b ready=%b fault=%b relock=%0d, expected state=%0d pll_rst=%b ready=%b fault=%b relock=%0d",
               e.tag, state, pllRst, audioReady, fault, relockCount,
               e.st, e.prst, e.rdy, e.flt, e.rc);
      $error("[TB] check %s did not match", e.tag);
    end
  endtask

  task automatic stepAndCheck(input int cycles, input string tag, input logic [2:0] st,
                              input logic prst, input logic rdy, input logic flt,
                              input logic [7:0] rc);
    pushExp(tag, st, prst, rdy, flt, rc);
    applyStimulus(cycles);
    checkOutput();
  endtask

  // Linear directed sequence covering bring-up, settle abort, loss filtering,
  // timeout to fault, restart/reset collisions and counter saturation.
  initial begin
    int rcPrev;
    int rcNow;

    $display("[TB] starting audio_pll_supervisor bench");

    stepAndCheck(2, "reset", HOLD, 1'b1, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    stepAndCheck(3, "hold_high", HOLD, 1'b1, 1'b0, 1'b0, 8'd0);
    stepAndCheck(1, "hold_release", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(4);
    lockAsync = 1'b1;
    stepAndCheck(2, "sync_latency", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd0);
    stepAndCheck(1, "settle_entry", SETTLE, 1'b0, 1'b0, 1'b0, 8'd0);
    stepAndCheck(7, "settle_hold", SETTLE, 1'b0, 1'b0, 1'b0, 8'd0);
    stepAndCheck(1, "ready_rise", RUN, 1'b0, 1'b1, 1'b0, 8'd0);

    lockAsync = 1'b0;
    applyStimulus(2);
    lockAsync = 1'b1;
    stepAndCheck(4, "glitch_ignored", RUN, 1'b0, 1'b1, 1'b0, 8'd0);

    lockAsync = 1'b0;
    applyStimulus(3);
    lockAsync = 1'b1;
    stepAndCheck(1, "loss_pending", RUN, 1'b0, 1'b1, 1'b0, 8'd0);
    stepAndCheck(1, "loss_detect", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    stepAndCheck(3, "relock_hold", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "relock_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "relock_settle", SETTLE, 1'b0, 1'b0, 1'b0, 8'd1);

    applyStimulus(2);
    lockAsync = 1'b0;
    applyStimulus(1);
    lockAsync = 1'b1;
    stepAndCheck(1, "abort_pending", SETTLE, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "abort_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "abort_resettle", SETTLE, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(7, "fresh_settle", SETTLE, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "abort_ready", RUN, 1'b0, 1'b1, 1'b0, 8'd1);

    restartReq = 1'b1;
    lockAsync  = 1'b0;
    stepAndCheck(1, "restart_run", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    restartReq = 1'b0;
    stepAndCheck(23, "timeout_win1", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "timeout_hold", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    stepAndCheck(3, "retry_hold", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "timeout_win2", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(19, "timeout_win2_end", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);
    stepAndCheck(1, "fault_entry", FAULT, 1'b1, 1'b0, 1'b1, 8'd1);
    stepAndCheck(5, "fault_sticky", FAULT, 1'b1, 1'b0, 1'b1, 8'd1);
    restartReq = 1'b1;
    stepAndCheck(1, "fault_restart", HOLD, 1'b1, 1'b0, 1'b0, 8'd1);
    restartReq = 1'b0;
    stepAndCheck(4, "restart_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 8'd1);

    rst        = 1'b1;
    restartReq = 1'b1;
    stepAndCheck(1, "rst_restart", HOLD, 1'b1, 1'b0, 1'b0, 8'd0);
    rst        = 1'b0;
    restartReq = 1'b0;
    lockAsync  = 1'b1;

    for (int k = 1; k <= 260; k++) begin
      rcPrev = (k - 1 > 255) ? 255 : k - 1;
      rcNow  = (k > 255) ? 255 : k;
      stepAndCheck(13, "sat_run", RUN, 1'b0, 1'b1, 1'b0, 8'(rcPrev));
      lockAsync = 1'b0;
      stepAndCheck(5, "sat_loss", HOLD, 1'b1, 1'b0, 1'b0, 8'(rcNow));
      lockAsync = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
